reg_dump_reader: RTL and testbench

- Read-side initiator for the 32x32 register file. On a Start pulse it walks all registers through the two read ports, Ard1 and Ard2, one register pair per read cycle.
- It streams each register value out, one word per beat, on a Valid/Ready interface. Consumers are the debug/trace path and the testbench scoreboard.
- Sits beside reg_file and drives only its read addresses. The write port stays owned by the datapath.

---
 rtl/reg_dump_reader_pkg.sv | 14 +
 rtl/reg_dump_reader_if.sv | 26 ++
 rtl/reg_dump_reader.sv | 103 ++++++++++
 tb/tb_reg_dump_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-file dump reader.
package reg_dump_reader_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SEND0 = 3'd2,
    ST_SEND1 = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-file read port pair plus the outgoing valid/ready beat stream.
interface reg_dump_reader_if #(
  parameter int ADDR_W = reg_dump_reader_pkg::ADDR_W,
  parameter int DATA_W = reg_dump_reader_pkg::DATA_W
);
  import reg_dump_reader_pkg::*;

  logic [ADDR_W-1:0] Ard1;
  logic [ADDR_W-1:0] Ard2;
  logic [DATA_W-1:0] Dout1;
  logic [DATA_W-1:0] Dout2;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutIdx;

  modport master (
    output Ard1, Ard2, OutValid, OutData, OutIdx,
    input  Dout1, Dout2, OutReady
  );

  modport slave (
    input  Ard1, Ard2, OutValid, OutData, OutIdx,
    output Dout1, Dout2, OutReady
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file one even/odd pair per READ cycle and streams each
// word out as a valid/ready beat; Done pulses once after the final beat.
module reg_dump_reader #(
  parameter int NUM_REGS = reg_dump_reader_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_dump_reader_pkg::ADDR_W,
  parameter int DATA_W   = reg_dump_reader_pkg::DATA_W
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Abort,
  output logic               Busy,
  output logic               Done,
  reg_dump_reader_if.master  bus
);
  import reg_dump_reader_pkg::*;

  // Pair index only needs ADDR_W-1 bits; register numbers are {p, lsb}.
  localparam int PW = ADDR_W - 1;
  localparam logic [PW-1:0] LAST_P = PW'(NUM_REGS / 2 - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    // Abort wins over a same-cycle handshake, so the beat is never counted.
    if (Abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (Start) begin
          state_d = ST_READ;
          p_d     = '0;
        end
        ST_READ: begin
          buf0_d  = bus.Dout1;
          buf1_d  = bus.Dout2;
          state_d = ST_SEND0;
        end
        ST_SEND0: if (bus.OutReady) state_d = ST_SEND1;
        ST_SEND1: if (bus.OutReady) begin
          if (p_q == LAST_P) begin
            state_d = ST_DONE;
          end else begin
            p_d     = p_q + PW'(1);
            state_d = ST_READ;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Addresses follow p outside IDLE, so they hold the last READ pair.
  always_comb begin
    bus.Ard1     = '0;
    bus.Ard2     = '0;
    bus.OutValid = 1'b0;
    bus.OutData  = '0;
    bus.OutIdx   = '0;
    Busy         = (state_q != ST_IDLE);
    Done         = 1'b0;
    if (state_q != ST_IDLE) begin
      bus.Ard1 = {p_q, 1'b0};
      bus.Ard2 = {p_q, 1'b1};
    end
    case (state_q)
      ST_SEND0: begin
        bus.OutValid = 1'b1;
        bus.OutData  = buf0_q;
        bus.OutIdx   = {p_q, 1'b0};
      end
      ST_SEND1: begin
        bus.OutValid = 1'b1;
        bus.OutData  = buf1_q;
        bus.OutIdx   = {p_q, 1'b1};
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench: register-file model, beat collector and a dump-level
// reference (value of each register as of its pair's read).
module tb_reg_dump_reader;
  import reg_dump_reader_pkg::*;

  logic Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, Abort = 1'b0;
  logic Busy, Done;
  reg_dump_reader_if bus ();

  logic [DATA_W-1:0] rf      [NUM_REGS];
  logic [DATA_W-1:0] ref_mem [NUM_REGS];
  assign bus.Dout1 = rf[bus.Ard1];
  assign bus.Dout2 = rf[bus.Ard2];

  reg_dump_reader dut (.Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
                       .Busy(Busy), .Done(Done), .bus(bus));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  int cfg_mode, cfg_stall_idx, cfg_abort_idx, cfg_rst_idx, cfg_wr_idx, cfg_wr_reg, cfg_max;
  logic cfg_hold_start, cfg_start_noise;
  logic [DATA_W-1:0] cfg_wr_val;

  logic [ADDR_W-1:0] got_idx[$];
  logic [DATA_W-1:0] got_data[$];
  logic              stall_v[$];
  logic [ADDR_W-1:0] stall_i[$];
  logic [DATA_W-1:0] stall_d[$];
  int n_done, done_cyc, busy_low, stab_err, last_acc;
  logic timed_out, snap_valid, snap_busy, snap_done;
  logic [49:0] snap_all;

  task automatic cfg_default();
    cfg_mode = 0; cfg_stall_idx = -1; cfg_abort_idx = -1; cfg_rst_idx = -1;
    cfg_wr_idx = -1; cfg_wr_reg = 0; cfg_wr_val = '0; cfg_max = 400;
    cfg_hold_start = 1'b0; cfg_start_noise = 1'b0;
  endtask

  task automatic preload(input logic rnd);
    for (int i = 0; i < NUM_REGS; i++) begin
      ref_mem[i] = (i == 0) ? '0 : (rnd ? DATA_W'($urandom) : 32'hA500_0000 + DATA_W'(i));
      rf[i] = ref_mem[i];
    end
  endtask

  // Pulses Start at cycle 0 and collects accepted beats until Busy drops after
  // Done, or one cycle past an injected Abort / reset.
  task automatic run_dump();
    int stall_cnt, end_k;
    logic stall_used, wr_used, pend, acc, rdy, fin;
    logic [ADDR_W-1:0] pidx;
    logic [DATA_W-1:0] pdata;
    got_idx.delete(); got_data.delete();
    stall_v.delete(); stall_i.delete(); stall_d.delete();
    n_done = 0; done_cyc = -1; busy_low = -1; stab_err = 0; last_acc = -1;
    stall_cnt = 0; end_k = -1; stall_used = 0; wr_used = 0; pend = 0; fin = 0;
    pidx = '0; pdata = '0;
    @(negedge Clk);
    Start = 1'b1; bus.OutReady = 1'b0;
    for (int k = 1; k <= cfg_max && !fin; k++) begin
      @(negedge Clk);
      if (pend && !(bus.OutValid && bus.OutIdx == pidx && bus.OutData == pdata)) stab_err++;
      if (Done) begin n_done++; done_cyc = k; end
      if (n_done > 0 && !Busy && busy_low < 0) busy_low = k;
      if (end_k == k) begin
        snap_valid = bus.OutValid; snap_busy = Busy; snap_done = Done;
        snap_all = {bus.Ard1, bus.Ard2, bus.OutValid, bus.OutData, bus.OutIdx, Busy, Done};
        fin = 1;
      end else if (end_k < 0 && busy_low > 0) begin
        fin = 1;
      end else begin
        Start = (cfg_hold_start && Busy) || (cfg_start_noise && Busy && $urandom_range(0, 3) == 0);
        Abort = 1'b0; Rst_n = 1'b1;
        case (cfg_mode)
          0:       rdy = 1'b1;
          1:       rdy = (k % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (cfg_stall_idx >= 0 && !stall_used && bus.OutValid && int'(bus.OutIdx) == cfg_stall_idx) begin
          stall_used = 1; stall_cnt = 5;
        end
        if (stall_cnt > 0) begin
          rdy = 1'b0; stall_cnt--;
          stall_v.push_back(bus.OutValid); stall_i.push_back(bus.OutIdx); stall_d.push_back(bus.OutData);
        end
        if (cfg_wr_idx >= 0 && !wr_used && bus.OutValid && int'(bus.OutIdx) == cfg_wr_idx) begin
          wr_used = 1; rf[cfg_wr_reg] = cfg_wr_val;
        end
        if (cfg_abort_idx >= 0 && end_k < 0 && bus.OutValid && int'(bus.OutIdx) == cfg_abort_idx) begin
          Abort = 1'b1; rdy = 1'b1; end_k = k + 1;
        end
        if (cfg_rst_idx >= 0 && end_k < 0 && bus.OutValid && int'(bus.OutIdx) == cfg_rst_idx) begin
          Rst_n = 1'b0; end_k = k + 1;
        end
        bus.OutReady = rdy;
        acc = bus.OutValid && rdy && !Abort && Rst_n;
        if (acc) begin got_idx.push_back(bus.OutIdx); got_data.push_back(bus.OutData); last_acc = k; end
        pend = bus.OutValid && !acc && !Abort && Rst_n;
        pidx = bus.OutIdx; pdata = bus.OutData;
      end
    end
    timed_out = !fin;
    Start = 1'b0; Abort = 1'b0; Rst_n = 1'b1; bus.OutReady = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b1; Abort = 1'b1; bus.OutReady = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if ({bus.Ard1, bus.Ard2, bus.OutValid, bus.OutData, bus.OutIdx, Busy, Done} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ard1=%0d ard2=%0d v=%b d=%h i=%0d busy=%b done=%b, want all 0",
               bus.Ard1, bus.Ard2, bus.OutValid, bus.OutData, bus.OutIdx, Busy, Done);
    end
    Rst_n = 1'b1; Start = 1'b0; Abort = 1'b0; bus.OutReady = 1'b0;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", Busy); end
  endtask

  task automatic test_full_dump();
    cfg_default(); preload(1'b0); run_dump();
    checks++;
    if (timed_out || got_idx.size() != NUM_REGS) begin
      errors++; $display("FAIL full_count: beats=%0d timeout=%b want %0d", got_idx.size(), timed_out, NUM_REGS);
    end
    foreach (got_idx[j]) begin
      checks++;
      if (got_idx[j] !== ADDR_W'(j) || got_data[j] !== ref_mem[j]) begin
        errors++; $display("FAIL full_beat%0d: idx=%0d data=%h want idx=%0d data=%h", j, got_idx[j], got_data[j], j, ref_mem[j]);
      end
    end
    checks++;
    if (done_cyc != 49 || busy_low != 50 || n_done != 1) begin
      errors++; $display("FAIL full_timing: done@%0d busy_low@%0d dones=%0d want 49 50 1", done_cyc, busy_low, n_done);
    end
    checks++;
    if (last_acc != 48 || stab_err != 0) begin
      errors++; $display("FAIL full_last_beat: last@%0d stab_err=%0d want 48 0", last_acc, stab_err);
    end
  endtask

  task automatic test_backpressure();
    cfg_default(); preload(1'b0); cfg_stall_idx = 6; run_dump();
    checks++;
    if (stall_v.size() != 5) begin errors++; $display("FAIL stall_len: got %0d want 5", stall_v.size()); end
    foreach (stall_v[j]) begin
      checks++;
      if (stall_v[j] !== 1'b1 || stall_i[j] !== 5'd6 || stall_d[j] !== 32'hA500_0006) begin
        errors++; $display("FAIL stall_hold%0d: v=%b idx=%0d data=%h want 1 6 a5000006", j, stall_v[j], stall_i[j], stall_d[j]);
      end
    end
    checks++;
    if (got_idx.size() != NUM_REGS || stab_err != 0 || n_done != 1) begin
      errors++; $display("FAIL stall_dump: beats=%0d stab_err=%0d dones=%0d want 32 0 1", got_idx.size(), stab_err, n_done);
    end
  endtask

  task automatic test_toggle_ready();
    int bad = 0;
    cfg_default(); preload(1'b0); cfg_mode = 1; run_dump();
    foreach (got_idx[j]) if (got_idx[j] !== ADDR_W'(j) || got_data[j] !== ref_mem[j]) bad++;
    checks++;
    if (got_idx.size() != NUM_REGS || bad != 0 || stab_err != 0) begin
      errors++; $display("FAIL toggle_beats: beats=%0d bad=%0d stab_err=%0d want 32 0 0", got_idx.size(), bad, stab_err);
    end
    checks++;
    if (n_done != 1 || done_cyc != last_acc + 1) begin
      errors++; $display("FAIL toggle_done: dones=%0d done@%0d last_beat@%0d want 1 and last+1", n_done, done_cyc, last_acc);
    end
  endtask

  task automatic test_abort();
    int late_done = 0;
    cfg_default(); preload(1'b0); cfg_abort_idx = 15; run_dump();
    checks++;
    if (got_idx.size() != 15 || snap_valid !== 1'b0 || snap_busy !== 1'b0 || snap_done !== 1'b0 || n_done != 0) begin
      errors++; $display("FAIL abort: beats=%0d v=%b busy=%b done=%b dones=%0d want 15 0 0 0 0",
                         got_idx.size(), snap_valid, snap_busy, snap_done, n_done);
    end
    repeat (4) begin @(negedge Clk); if (Done || Busy) late_done++; end
    checks++;
    if (late_done != 0) begin errors++; $display("FAIL abort_idle: busy/done cycles=%0d want 0", late_done); end
    cfg_default(); run_dump();
    checks++;
    if (got_idx.size() != NUM_REGS || got_idx[0] !== '0 || got_idx[NUM_REGS-1] !== 5'd31 || n_done != 1) begin
      errors++; $display("FAIL abort_restart: beats=%0d dones=%0d want 32 beats from idx 0 and 1 done", got_idx.size(), n_done);
    end
  endtask

  task automatic test_start_held();
    int extra = 0;
    cfg_default(); preload(1'b0); cfg_hold_start = 1'b1; run_dump();
    repeat (6) begin @(negedge Clk); if (Busy || Done) extra++; end
    checks++;
    if (got_idx.size() != NUM_REGS || n_done != 1 || done_cyc != 49 || extra != 0) begin
      errors++; $display("FAIL start_held: beats=%0d dones=%0d done@%0d busy_after=%0d want 32 1 49 0",
                         got_idx.size(), n_done, done_cyc, extra);
    end
  endtask

  task automatic test_random_noise();
    int bad;
    for (int r = 0; r < 3; r++) begin
      bad = 0;
      cfg_default(); preload(1'b1); cfg_mode = 2; cfg_start_noise = 1'b1; run_dump();
      foreach (got_idx[j]) if (got_idx[j] !== ADDR_W'(j) || got_data[j] !== ref_mem[j]) bad++;
      checks++;
      if (timed_out || got_idx.size() != NUM_REGS || bad != 0 || stab_err != 0 || n_done != 1) begin
        errors++; $display("FAIL random%0d: beats=%0d bad=%0d stab_err=%0d dones=%0d timeout=%b want 32 0 0 1 0",
                           r, got_idx.size(), bad, stab_err, n_done, timed_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    cfg_default(); preload(1'b0); cfg_rst_idx = 20; run_dump();
    checks++;
    if (snap_all !== 50'd0 || n_done != 0 || got_idx.size() != 20) begin
      errors++; $display("FAIL reset_mid: outs=%h dones=%0d beats=%0d want 0 0 20", snap_all, n_done, got_idx.size());
    end
    repeat (4) begin @(negedge Clk); if (Done || Busy) late++; end
    checks++;
    if (late != 0) begin errors++; $display("FAIL reset_mid_idle: busy/done cycles=%0d want 0", late); end
  endtask

  // A write becomes visible only if its register's pair has not yet been read;
  // the write is issued while beat wr_idx is on the bus (its pair already read).
  task automatic test_write(input int wr_idx, input int reg_n, input logic [DATA_W-1:0] val);
    cfg_default(); preload(1'b0);
    cfg_wr_idx = wr_idx; cfg_wr_reg = reg_n; cfg_wr_val = val;
    if (reg_n / 2 > wr_idx / 2) ref_mem[reg_n] = val;
    run_dump();
    checks++;
    if (got_idx.size() != NUM_REGS || got_data[reg_n] !== ref_mem[reg_n]) begin
      errors++; $display("FAIL write_reg%0d: beats=%0d data=%h want %h", reg_n, got_idx.size(),
                         (got_data.size() > reg_n) ? got_data[reg_n] : '0, ref_mem[reg_n]);
    end
  endtask

  initial begin
    bus.OutReady = 1'b0;
    preload(1'b0);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_toggle_ready();
    test_abort();
    test_start_held();
    test_random_noise();
    test_reset_mid();
    test_write(19, 20, 32'h1234_5678);
    test_write(4, 4, 32'hDEAD_BEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
